gamma_lut_stream: RTL

GAMMA_LUT_STREAM -- requirements
Module: gamma_lut_stream

---
 rtl/gamma_pkg.sv | 15 +
 rtl/gamma_lut_ram.sv | 24 ++
 rtl/gamma_lut_stream.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gamma_pkg.sv
// Shared types and defaults for the gamma correction stream: FSM states,
// default channel geometry and the config-channel index width helper.
package gamma_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int CHANNELS_DEF = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gamma_lut_ram.sv
// Single-clock LUT storage for one colour channel: registered read with enable,
// one write port, read-before-write on a same-address collision.
module gamma_lut_ram #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              re,
  input  logic [DATA_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [DATA_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] mem_q [0:(1<<DATA_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Plain array with no reset keeps this mappable onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/gamma_lut_stream.sv
// Per-channel gamma LUT on a valid/ready pixel stream. After reset every LUT is
// loaded with identity, then pixels flow through a 2-stage pipeline.
module gamma_lut_stream
  import gamma_pkg::*;
#(
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  CHANNELS = CHANNELS_DEF,
  localparam int CH_W     = ch_w(CHANNELS),
  localparam int PIX_W    = CHANNELS * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_last,
  input  logic              bypass,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DATA_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              init_done
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic              s1_bypass_q, s1_bypass_d;
  logic [PIX_W-1:0]  s1_data_q, s1_data_d, m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic              run, adv;

  logic [CHANNELS-1:0]              lut_we;
  logic [DATA_W-1:0]                lut_waddr, lut_wdata;
  logic [CHANNELS-1:0][DATA_W-1:0]  lut_rdata;

  assign run       = (state_q == ST_RUN);
  assign adv       = run && (m_ready || !m_valid_q);
  assign s_ready   = adv;
  assign init_done = run;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;

  // INIT owns the write port to sweep identity into every LUT; cfg writes only in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lut_we    = '0;
    lut_waddr = cfg_addr;
    lut_wdata = cfg_data;
    if (!run) begin
      lut_we    = '1;
      lut_waddr = cnt_q;
      lut_wdata = cnt_q;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end else if (cfg_we) begin
      for (int c = 0; c < CHANNELS; c++) lut_we[c] = (cfg_ch == CH_W'(c));
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    s1_bypass_d = s1_bypass_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    if (adv) begin
      s1_valid_d  = s_valid;
      s1_data_d   = s_data;
      s1_last_d   = s_last;
      s1_bypass_d = bypass;
      m_valid_d   = s1_valid_q;
      m_last_d    = s1_last_q;
      // Bubbles leave m_data alone rather than loading stale RAM output.
      if (s1_valid_q) m_data_d = s1_bypass_q ? s1_data_q : lut_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_bypass_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_last_q   <= s1_last_d;
      s1_bypass_q <= s1_bypass_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
    end
  end

  // The read is issued with the stage-1 capture, so RAM output lines up with stage 1.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lut
    gamma_lut_ram #(.DATA_W(DATA_W)) u_lut (
      .clk   (clk),
      .re    (adv),
      .raddr (s_data[c*DATA_W +: DATA_W]),
      .rdata (lut_rdata[c]),
      .we    (lut_we[c]),
      .waddr (lut_waddr),
      .wdata (lut_wdata)
    );
  end
endmodule
